// File: rtl/aib_io_cfg_bank_if.sv
// Host-side bus of the AIB IO config bank: staging writes plus commit handshake.
interface aib_io_cfg_bank_if #(
    parameter int NumIo = 20,
    parameter int IdxW  = (NumIo > 1) ? $clog2(NumIo) : 1
);
    logic            i_wr_valid;
    logic            o_wr_ready;
    logic [IdxW-1:0] i_wr_idx;
    logic [26:0]     i_wr_data;
    logic            o_wr_err;
    logic            i_commit;
    logic            o_busy;
    logic            o_commit_done;

    modport master (
        output i_wr_valid, i_wr_idx, i_wr_data, i_commit,
        input  o_wr_ready, o_wr_err, o_busy, o_commit_done
    );

    modport slave (
        input  i_wr_valid, i_wr_idx, i_wr_data, i_commit,
        output o_wr_ready, o_wr_err, o_busy, o_commit_done
    );
endinterface

// File: rtl/aib_io_cfg_bank.sv
// Per-IO configuration bank for an AIB IO block. Host writes land in a staging
// copy; a commit swaps staging into the active copy in one edge, with tx_en held
// low on every changed channel for a guard window on both sides of the swap.
module aib_io_cfg_bank #(
    parameter int  NumIo       = 20,
    parameter int  GuardCycles = 4,
    localparam int IdxW        = (NumIo > 1) ? $clog2(NumIo) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    aib_io_cfg_bank_if.slave     io_bus,
    output logic [NumIo-1:0]     o_c_ddr_mode,
    output logic [NumIo-1:0]     o_c_async_mode,
    output logic [NumIo-1:0]     o_c_tx_en,
    output logic [NumIo-1:0]     o_c_pull_en,
    output logic [NumIo-1:0]     o_c_pull_dir,
    output logic [3*NumIo-1:0]   o_c_pdrv,
    output logic [3*NumIo-1:0]   o_c_ndrv,
    output logic [8*NumIo-1:0]   o_c_tx_dly_tap,
    output logic [8*NumIo-1:0]   o_c_rx_dly_tap
);

    typedef enum logic [2:0] {
        S_IDLE, S_EVAL, S_QUIESCE, S_APPLY, S_SETTLE, S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_pend;
    logic [7:0]                r_cnt;
    logic [NumIo-1:0]          r_dirty;
    logic                      r_wr_err;
    logic [NumIo-1:0][26:0]    r_stg;
    logic [NumIo-1:0][26:0]    r_act;

    logic [NumIo-1:0]          w_dirty;
    logic                      w_wr_ready;
    logic                      w_wr_fire;
    logic                      w_idx_bad;
    logic                      w_commit_take;
    logic                      w_guard_last;
    logic                      w_hold;
    logic                      w_done;

    assign w_wr_fire     = io_bus.i_wr_valid && w_wr_ready;
    assign w_idx_bad     = {1'b0, io_bus.i_wr_idx} >= (IdxW+1)'(NumIo);
    assign w_commit_take = io_bus.i_commit && (r_state == S_IDLE) && !r_pend;
    assign w_guard_last  = (r_cnt == 8'(GuardCycles - 1));

    // A channel is dirty when its staged word differs from what is driving the pad
    for (genvar gi = 0; gi < NumIo; gi++) begin : g_dirty
        assign w_dirty[gi] = (r_stg[gi] != r_act[gi]);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: skip the guard sequence entirely when nothing changed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_commit_take) w_state_nxt = S_EVAL;
            S_EVAL:    w_state_nxt = (|w_dirty) ? S_QUIESCE : S_DONE;
            S_QUIESCE: if (w_guard_last) w_state_nxt = S_APPLY;
            S_APPLY:   w_state_nxt = S_SETTLE;
            S_SETTLE:  if (w_guard_last) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: tx hold spans quiesce, the apply edge and settle
    always_comb begin
        w_hold     = (r_state == S_QUIESCE) || (r_state == S_APPLY) || (r_state == S_SETTLE);
        w_done     = (r_state == S_DONE);
        w_wr_ready = (r_state == S_IDLE) && !r_pend;
    end

    assign io_bus.o_wr_ready    = w_wr_ready;
    assign io_bus.o_busy        = r_pend || (r_state != S_IDLE);
    assign io_bus.o_commit_done = w_done;
    assign io_bus.o_wr_err      = r_wr_err;

    // Datapath: staging writes, dirty capture, guard counter, atomic apply
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend   <= 1'b0;
            r_cnt    <= '0;
            r_dirty  <= '0;
            r_wr_err <= 1'b0;
            r_stg    <= '0;
            r_act    <= '0;
        end else begin
            r_wr_err <= w_wr_fire && w_idx_bad;

            if (w_commit_take)          r_pend <= 1'b1;
            else if (r_state == S_EVAL) r_pend <= 1'b0;

            if (r_state == S_EVAL)      r_dirty <= w_dirty;
            else if (r_state == S_DONE) r_dirty <= '0;

            if (((r_state == S_QUIESCE) || (r_state == S_SETTLE)) && !w_guard_last)
                r_cnt <= r_cnt + 8'd1;
            else
                r_cnt <= '0;

            if (r_state == S_APPLY) r_act <= r_stg;

            // Index compare per channel keeps out-of-range indices from touching storage
            for (int gi = 0; gi < NumIo; gi++) begin
                if (w_wr_fire && !w_idx_bad && (io_bus.i_wr_idx == IdxW'(gi)))
                    r_stg[gi] <= io_bus.i_wr_data;
            end
        end
    end

    // Unpack active words onto the IO block control buses
    for (genvar gi = 0; gi < NumIo; gi++) begin : g_out
        assign o_c_ddr_mode[gi]          = r_act[gi][0];
        assign o_c_async_mode[gi]        = r_act[gi][1];
        assign o_c_tx_en[gi]             = r_act[gi][2] & ~(w_hold & r_dirty[gi]);
        assign o_c_pull_en[gi]           = r_act[gi][3];
        assign o_c_pull_dir[gi]          = r_act[gi][4];
        assign o_c_pdrv[3*gi +: 3]       = r_act[gi][7:5];
        assign o_c_ndrv[3*gi +: 3]       = r_act[gi][10:8];
        assign o_c_tx_dly_tap[8*gi +: 8] = r_act[gi][18:11];
        assign o_c_rx_dly_tap[8*gi +: 8] = r_act[gi][26:19];
    end

endmodule

// File: tb/tb_aib_io_cfg_bank.sv
// Randomized self-checking bench for aib_io_cfg_bank against a field-level model.
module tb_aib_io_cfg_bank;
    localparam int NI = 20;
    localparam int G  = 4;
    localparam int IW = 5;
    localparam int NB = 27 * NI;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    aib_io_cfg_bank_if #(.NumIo(NI)) bus ();
    aib_io_cfg_bank_if #(.NumIo(1))  bus2 ();

    logic [NI-1:0]   c_ddr, c_asy, c_tx, c_pe, c_pd;
    logic [3*NI-1:0] c_pdv, c_ndv;
    logic [8*NI-1:0] c_td, c_rd;
    wire  [NB-1:0]   dut_c = {c_rd, c_td, c_ndv, c_pdv, c_pd, c_pe, c_tx, c_asy, c_ddr};

    logic       d2_ddr, d2_asy, d2_tx, d2_pe, d2_pd;
    logic [2:0] d2_pdv, d2_ndv;
    logic [7:0] d2_td, d2_rd;

    aib_io_cfg_bank #(.NumIo(NI), .GuardCycles(G)) dut (
        .i_clk(clk), .i_rst(rst), .io_bus(bus),
        .o_c_ddr_mode(c_ddr), .o_c_async_mode(c_asy), .o_c_tx_en(c_tx),
        .o_c_pull_en(c_pe), .o_c_pull_dir(c_pd), .o_c_pdrv(c_pdv), .o_c_ndrv(c_ndv),
        .o_c_tx_dly_tap(c_td), .o_c_rx_dly_tap(c_rd)
    );

    aib_io_cfg_bank #(.NumIo(1), .GuardCycles(1)) dut2 (
        .i_clk(clk), .i_rst(rst2), .io_bus(bus2),
        .o_c_ddr_mode(d2_ddr), .o_c_async_mode(d2_asy), .o_c_tx_en(d2_tx),
        .o_c_pull_en(d2_pe), .o_c_pull_dir(d2_pd), .o_c_pdrv(d2_pdv), .o_c_ndrv(d2_ndv),
        .o_c_tx_dly_tap(d2_td), .o_c_rx_dly_tap(d2_rd)
    );

    int n_pass = 0;
    int n_chk  = 0;

    logic [26:0] m_act   [NI];
    logic [26:0] m_stg   [NI];
    bit          m_dirty [NI];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected control buses: old or new words per channel, tx masked on dirty channels under hold
    function automatic logic [NB-1:0] model_c(input bit newv, input bit hold);
        logic [NI-1:0]   ddr, asy, tx, pe, pd;
        logic [3*NI-1:0] pdv, ndv;
        logic [8*NI-1:0] td, rd;
        logic [26:0]     w;
        for (int ch = 0; ch < NI; ch++) begin
            w = newv ? m_stg[ch] : m_act[ch];
            ddr[ch] = w[0];
            asy[ch] = w[1];
            tx[ch]  = w[2] & !(hold && m_dirty[ch]);
            pe[ch]  = w[3];
            pd[ch]  = w[4];
            pdv[3*ch +: 3] = w[7:5];
            ndv[3*ch +: 3] = w[10:8];
            td[8*ch +: 8]  = w[18:11];
            rd[8*ch +: 8]  = w[26:19];
        end
        return {rd, td, ndv, pdv, pd, pe, tx, asy, ddr};
    endfunction

    task automatic model_clear();
        for (int ch = 0; ch < NI; ch++) begin
            m_act[ch] = '0; m_stg[ch] = '0; m_dirty[ch] = 1'b0;
        end
    endtask

    task automatic do_write(input int idx, input logic [26:0] data);
        n_chk++;
        if (bus.o_wr_ready !== 1'b1) $display("FAIL wr_ready_before_write: got %b want 1", bus.o_wr_ready);
        else n_pass++;
        bus.i_wr_valid = 1'b1; bus.i_wr_idx = IW'(idx); bus.i_wr_data = data;
        step();
        bus.i_wr_valid = 1'b0;
        if (idx < NI) m_stg[idx] = data;
        n_chk++;
        if (bus.o_wr_err !== (idx >= NI)) $display("FAIL wr_err idx=%0d: got %b want %b", idx, bus.o_wr_err, idx >= NI);
        else n_pass++;
        n_chk++;
        if (dut_c !== model_c(0, 0)) $display("FAIL write_no_effect idx=%0d: got %h want %h", idx, dut_c, model_c(0, 0));
        else n_pass++;
    endtask

    // Commit from cycle 0 and check every cycle until one past the done pulse
    task automatic commit_seq(input string tag, input bit wr_same, input int widx,
                              input logic [26:0] wdata, input bit disturb);
        bit anyd;
        int endk;
        logic [NB-1:0] exp_c;
        bit exp_busy;
        bus.i_commit = 1'b1;
        if (wr_same) begin
            bus.i_wr_valid = 1'b1; bus.i_wr_idx = IW'(widx); bus.i_wr_data = wdata;
            m_stg[widx] = wdata;
        end
        anyd = 1'b0;
        for (int ch = 0; ch < NI; ch++) begin
            m_dirty[ch] = (m_stg[ch] != m_act[ch]);
            anyd |= m_dirty[ch];
        end
        endk = anyd ? 2*G + 3 : 2;
        for (int k = 1; k <= endk + 1; k++) begin
            step();
            bus.i_commit = 1'b0; bus.i_wr_valid = 1'b0;
            exp_c    = model_c(anyd && k >= G + 3, anyd && k >= 2 && k <= 2*G + 2);
            exp_busy = (k <= endk);
            n_chk++;
            if (dut_c !== exp_c) $display("FAIL %s c_out k=%0d: got %h want %h", tag, k, dut_c, exp_c);
            else n_pass++;
            n_chk++;
            if (bus.o_busy !== exp_busy) $display("FAIL %s busy k=%0d: got %b want %b", tag, k, bus.o_busy, exp_busy);
            else n_pass++;
            n_chk++;
            if (bus.o_commit_done !== (k == endk)) $display("FAIL %s done k=%0d: got %b want %b", tag, k, bus.o_commit_done, k == endk);
            else n_pass++;
            n_chk++;
            if (bus.o_wr_ready !== !exp_busy) $display("FAIL %s wr_ready k=%0d: got %b want %b", tag, k, bus.o_wr_ready, !exp_busy);
            else n_pass++;
            if (disturb && anyd && k == 3) begin
                bus.i_wr_valid = 1'b1; bus.i_wr_idx = IW'($urandom_range(NI-1)); bus.i_wr_data = 27'($urandom());
            end
            if (disturb && anyd && k == G + 3) bus.i_commit = 1'b1;
        end
        for (int ch = 0; ch < NI; ch++) begin
            m_act[ch] = m_stg[ch]; m_dirty[ch] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        model_clear();
        n_chk++;
        if (dut_c !== '0) $display("FAIL reset_c_out: got %h want 0", dut_c); else n_pass++;
        n_chk++;
        if (bus.o_wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b want 1", bus.o_wr_ready); else n_pass++;
        n_chk++;
        if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.o_busy); else n_pass++;
        n_chk++;
        if ({bus.o_wr_err, bus.o_commit_done} !== 2'b00)
            $display("FAIL reset_pulses: got %b want 00", {bus.o_wr_err, bus.o_commit_done});
        else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_first_commit();
        do_write(3, 27'h000_0004);
        commit_seq("first_commit", 0, 0, '0, 0);
    endtask

    task automatic test_guarded_update();
        do_write(5, 27'h0E4);
        do_write(6, 27'h004);
        commit_seq("setup_ch5_ch6", 0, 0, '0, 0);
        do_write(5, 27'h064);
        commit_seq("guarded_pdrv", 0, 0, '0, 0);
    endtask

    task automatic test_no_change();
        commit_seq("no_change", 0, 0, '0, 0);
    endtask

    task automatic test_wr_err();
        do_write(NI, 27'h7FF_FFFF);
        step();
        n_chk++;
        if (bus.o_wr_err !== 1'b0) $display("FAIL wr_err_single_pulse: got %b want 0", bus.o_wr_err); else n_pass++;
        commit_seq("after_bad_idx", 0, 0, '0, 0);
    endtask

    task automatic test_same_cycle();
        commit_seq("same_cycle_write", 1, 0, 27'h5A5_A5A5, 1);
        commit_seq("post_disturb_nochg", 0, 0, '0, 0);
    endtask

    task automatic test_random();
        int nw, idx;
        for (int r = 0; r < 8; r++) begin
            nw = $urandom_range(4);
            for (int w = 0; w < nw; w++) begin
                idx = $urandom_range(31);
                if ($urandom_range(3) == 0 && idx < NI) do_write(idx, m_act[idx]);
                else do_write(idx, 27'($urandom()));
            end
            commit_seq($sformatf("random_%0d", r), $urandom_range(1), $urandom_range(NI-1),
                       27'($urandom()), $urandom_range(1));
        end
    endtask

    task automatic test_reset_mid();
        do_write(2, 27'h7FF_FFFF);
        bus.i_commit = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            bus.i_commit = 1'b0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        n_chk++;
        if (dut_c !== '0) $display("FAIL midreset_c_out: got %h want 0", dut_c); else n_pass++;
        n_chk++;
        if (bus.o_wr_ready !== 1'b1) $display("FAIL midreset_wr_ready: got %b want 1", bus.o_wr_ready); else n_pass++;
        for (int k = 0; k < 12; k++) begin
            n_chk++;
            if ({bus.o_busy, bus.o_commit_done} !== 2'b00)
                $display("FAIL midreset_quiet k=%0d: got %b want 00", k, {bus.o_busy, bus.o_commit_done});
            else n_pass++;
            step();
        end
        commit_seq("after_midreset", 0, 0, '0, 0);
    endtask

    // NumIo=1, GuardCycles=1: first commit turns tx on, second changes pdrv under guard
    task automatic test_param_sweep();
        bit exp_tx;
        logic [2:0] exp_pdv;
        rst2 = 1'b0;
        step();
        bus2.i_wr_valid = 1'b1; bus2.i_wr_idx = 1'b1; bus2.i_wr_data = 27'h7FF_FFFF;
        step();
        bus2.i_wr_valid = 1'b0;
        n_chk++;
        if (bus2.o_wr_err !== 1'b1) $display("FAIL sweep_wr_err: got %b want 1", bus2.o_wr_err); else n_pass++;
        for (int pass = 0; pass < 2; pass++) begin
            bus2.i_wr_valid = 1'b1; bus2.i_wr_idx = 1'b0;
            bus2.i_wr_data = (pass == 0) ? 27'h0A4 : 27'h044;
            bus2.i_commit = 1'b1;
            for (int k = 1; k <= 6; k++) begin
                step();
                bus2.i_wr_valid = 1'b0; bus2.i_commit = 1'b0;
                n_chk++;
                if (bus2.o_commit_done !== (k == 5)) $display("FAIL sweep_done p%0d k=%0d: got %b want %b", pass, k, bus2.o_commit_done, k == 5);
                else n_pass++;
                exp_tx  = (pass == 0) ? (k >= 5) : (k < 2 || k >= 5);
                exp_pdv = (k >= 4) ? ((pass == 0) ? 3'd5 : 3'd2) : ((pass == 0) ? 3'd0 : 3'd5);
                n_chk++;
                if ({d2_tx, d2_pdv} !== {exp_tx, exp_pdv})
                    $display("FAIL sweep_out p%0d k=%0d: got %h want %h", pass, k, {d2_tx, d2_pdv}, {exp_tx, exp_pdv});
                else n_pass++;
            end
        end
    endtask

    initial begin
        bus.i_wr_valid = 1'b0; bus.i_wr_idx = '0; bus.i_wr_data = '0; bus.i_commit = 1'b0;
        bus2.i_wr_valid = 1'b0; bus2.i_wr_idx = '0; bus2.i_wr_data = '0; bus2.i_commit = 1'b0;
        test_reset();
        test_first_commit();
        test_guarded_update();
        test_no_change();
        test_wr_err();
        test_same_cycle();
        test_random();
        test_reset_mid();
        test_param_sweep();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
